// File: rtl/recompute_unit_if.sv
// Recompute unit bus bundle: job request, operand read port and result handshake.
// Ports (via modports):
//   master - recompute controller / operand memory / result sink side
//   slave  - recompute unit side
// job_*: job offer (valid/ready + faulty PE row/col)
// rd_*:  operand read strobe and addresses; data_in/weight_in return one cycle later
// res_*: corrected result (valid/ready + row/col tags + dot product)
interface recompute_unit_if #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned K      = 4,
   parameter int unsigned DATA_W = 8
);
   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned IDX_W = $clog2(K);
   localparam int unsigned ACC_W = 2 * DATA_W + $clog2(K);

   logic                     job_valid;
   logic                     job_ready;
   logic [ROW_W-1:0]         job_row;
   logic [COL_W-1:0]         job_col;

   logic                     rd_en;
   logic [ROW_W-1:0]         rd_row;
   logic [COL_W-1:0]         rd_col;
   logic [IDX_W-1:0]         rd_idx;
   logic signed [DATA_W-1:0] data_in;
   logic signed [DATA_W-1:0] weight_in;

   logic                     res_valid;
   logic                     res_ready;
   logic [ROW_W-1:0]         res_row;
   logic [COL_W-1:0]         res_col;
   logic signed [ACC_W-1:0]  res_data;

   modport master (
      output job_valid, job_row, job_col, data_in, weight_in, res_ready,
      input  job_ready, rd_en, rd_row, rd_col, rd_idx,
             res_valid, res_row, res_col, res_data
   );

   modport slave (
      input  job_valid, job_row, job_col, data_in, weight_in, res_ready,
      output job_ready, rd_en, rd_row, rd_col, rd_idx,
             res_valid, res_row, res_col, res_data
   );
endinterface

// File: rtl/recompute_unit.sv
// Recompute unit: recomputes one systolic-array PE output (a K-long signed dot
// product of data row rd_row and weight column rd_col) for fault correction.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   bus        - recompute_unit_if.slave (job, operand read, result handshake)
//   busy       - high whenever the unit is not idle
//   jobs_done  - saturating count of completed result handshakes
module recompute_unit #(
   parameter int unsigned ROWS   = 4,
   parameter int unsigned COLS   = 4,
   parameter int unsigned K      = 4,
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   recompute_unit_if.slave       bus,
   output logic                  busy,
   output logic [15:0]           jobs_done
);
   localparam int unsigned ROW_W = $clog2(ROWS);
   localparam int unsigned COL_W = $clog2(COLS);
   localparam int unsigned IDX_W = $clog2(K);
   localparam int unsigned ACC_W = 2 * DATA_W + $clog2(K);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t                  state, state_nxt;
   logic [IDX_W-1:0]        k_q;
   logic [ROW_W-1:0]        row_q;
   logic [COL_W-1:0]        col_q;
   logic signed [ACC_W-1:0] acc_q;
   logic                    rd_d1_q;
   logic                    job_ready_q, rd_en_q, res_valid_q, busy_q;

   logic                    job_fire_c, res_fire_c, last_k_c;
   logic signed [ACC_W-1:0] data_ext_c, weight_ext_c, prod_c;

   assign job_fire_c = bus.job_valid && job_ready_q;
   assign res_fire_c = res_valid_q && bus.res_ready;
   assign last_k_c   = (k_q == IDX_W'(K - 1));

   // Full-precision signed product; ACC_W holds K worst-case products, so no overflow.
   assign data_ext_c   = ACC_W'(bus.data_in);
   assign weight_ext_c = ACC_W'(bus.weight_in);
   assign prod_c       = data_ext_c * weight_ext_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (job_fire_c) state_nxt = FETCH;
         FETCH:   if (last_k_c)   state_nxt = DRAIN;
         DRAIN:   state_nxt = DONE;
         DONE:    if (res_fire_c) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Status flags registered from the next state so they track the state exactly
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         job_ready_q <= 1'b1;
         rd_en_q     <= 1'b0;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         job_ready_q <= (state_nxt == IDLE);
         rd_en_q     <= (state_nxt == FETCH);
         res_valid_q <= (state_nxt == DONE);
         busy_q      <= (state_nxt != IDLE);
      end
   end

   // Datapath: operands arrive one cycle after each read, so accumulate on the delayed strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         k_q       <= '0;
         row_q     <= '0;
         col_q     <= '0;
         acc_q     <= '0;
         rd_d1_q   <= 1'b0;
         jobs_done <= '0;
      end else begin
         rd_d1_q <= rd_en_q;
         if (job_fire_c) begin
            row_q <= bus.job_row;
            col_q <= bus.job_col;
            acc_q <= '0;
            k_q   <= '0;
         end else begin
            if (rd_d1_q) acc_q <= acc_q + prod_c;
            if ((state == FETCH) && !last_k_c) k_q <= k_q + IDX_W'(1);
         end
         if (res_fire_c && (jobs_done != 16'hFFFF)) jobs_done <= jobs_done + 16'd1;
      end
   end

   assign bus.job_ready = job_ready_q;
   assign bus.rd_en     = rd_en_q;
   assign bus.rd_row    = row_q;
   assign bus.rd_col    = col_q;
   assign bus.rd_idx    = k_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_row   = row_q;
   assign bus.res_col   = col_q;
   assign bus.res_data  = acc_q;
   assign busy          = busy_q;
endmodule

// File: tb/tb_recompute_unit.sv
// Testbench for recompute_unit: directed and randomized jobs checked against a
// dot-product model computed from behavioural data/weight matrices.
module tb_recompute_unit;
   localparam int unsigned ROWS   = 4;
   localparam int unsigned COLS   = 4;
   localparam int unsigned K      = 4;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned ROW_W  = $clog2(ROWS);
   localparam int unsigned COL_W  = $clog2(COLS);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        busy;
   logic [15:0] jobs_done;

   int errors   = 0;
   int checks   = 0;
   int cyc      = 0;
   int done_cnt = 0;

   int dmem [ROWS][K];
   int wmem [K][COLS];

   logic pend = 1'b0;
   int   prow = 0, pcol = 0, pidx = 0;

   recompute_unit_if #(.ROWS(ROWS), .COLS(COLS), .K(K), .DATA_W(DATA_W)) bus ();

   recompute_unit #(.ROWS(ROWS), .COLS(COLS), .K(K), .DATA_W(DATA_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .busy      (busy),
      .jobs_done (jobs_done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Operand memory: answers a read one cycle later, garbage otherwise
   always @(negedge clk) begin
      pend = bus.rd_en;
      prow = int'(bus.rd_row);
      pcol = int'(bus.rd_col);
      pidx = int'(bus.rd_idx);
   end
   always @(posedge clk) begin
      #1;
      if (pend === 1'b1) begin
         bus.data_in   = DATA_W'(dmem[prow][pidx]);
         bus.weight_in = DATA_W'(wmem[pidx][pcol]);
      end else begin
         bus.data_in   = DATA_W'($urandom);
         bus.weight_in = DATA_W'($urandom);
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic longint dot(input int r, input int c);
      longint s = 0;
      for (int k = 0; k < K; k++) s += longint'(dmem[r][k]) * longint'(wmem[k][c]);
      return s;
   endfunction

   task automatic fill_random();
      for (int i = 0; i < ROWS; i++)
         for (int k = 0; k < K; k++) dmem[i][k] = int'($urandom_range(255)) - 128;
      for (int k = 0; k < K; k++)
         for (int j = 0; j < COLS; j++) wmem[k][j] = int'($urandom_range(255)) - 128;
   endtask

   // One job end to end; stall = cycles res_ready stays low after res_valid
   task automatic do_job(input int r, input int c, input longint exp_v, input int stall,
                         input bit poke, input bit pend_next);
      int n = 0;
      bus.job_row   = ROW_W'(r);
      bus.job_col   = COL_W'(c);
      bus.job_valid = 1'b1;
      while (bus.job_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         check("accept_timeout", 0, 1);
         bus.job_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 bus.job_valid = 1'b0;
      for (int k = 0; k < K; k++) begin
         @(negedge clk);
         check("rd_en_fetch", bus.rd_en, 1);
         check("rd_idx", bus.rd_idx, k);
         if (k == 0) begin
            check("rd_row", bus.rd_row, r);
            check("rd_col", bus.rd_col, c);
         end
         if (poke && k == 1) begin
            bus.job_row   = ROW_W'(r + 1);
            bus.job_valid = 1'b1;
         end
         if (poke && k == 2) bus.job_valid = 1'b0;
      end
      @(negedge clk);
      check("rd_en_drain", bus.rd_en, 0);
      check("res_valid_early", bus.res_valid, 0);
      @(negedge clk);
      check("res_valid", bus.res_valid, 1);
      check("res_data", bus.res_data, exp_v);
      check("res_row", bus.res_row, r);
      check("res_col", bus.res_col, c);
      check("job_ready_done", bus.job_ready, 0);
      if (pend_next) bus.job_valid = 1'b1;
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check("stall_valid", bus.res_valid, 1);
         check("stall_data", bus.res_data, exp_v);
         check("stall_job_ready", bus.job_ready, 0);
      end
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      if (done_cnt < 65535) done_cnt++;
      @(negedge clk);
      check("idle_res_valid", bus.res_valid, 0);
      check("idle_job_ready", bus.job_ready, 1);
      check("jobs_done", jobs_done, done_cnt);
   endtask

   initial begin
      int br [3] = '{0, 2, 1};
      int bc [3] = '{1, 3, 0};
      int acc_cyc [3];
      int r, c, n;
      bit saw;

      bus.job_valid = 1'b0;
      bus.job_row   = '0;
      bus.job_col   = '0;
      bus.res_ready = 1'b0;
      for (int i = 0; i < ROWS; i++) for (int k = 0; k < K; k++) dmem[i][k] = 0;
      for (int k = 0; k < K; k++) for (int j = 0; j < COLS; j++) wmem[k][j] = 0;

      // Reset state
      #2;
      check("rst_busy", busy, 0);
      check("rst_res_valid", bus.res_valid, 0);
      check("rst_rd_en", bus.rd_en, 0);
      check("rst_jobs_done", jobs_done, 0);
      check("rst_res_data", bus.res_data, 0);
      check("rst_res_row", bus.res_row, 0);
      check("rst_res_col", bus.res_col, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_job_ready", bus.job_ready, 1);

      // Basic job
      for (int k = 0; k < K; k++) begin
         dmem[1][k] = k + 1;
         wmem[k][2] = k + 5;
      end
      do_job(1, 2, 70, 0, 0, 0);

      // Signed extremes
      for (int k = 0; k < K; k++) begin
         dmem[0][k] = -128;
         wmem[k][0] = -128;
         wmem[k][3] = 1;
      end
      dmem[2][0] = -1; dmem[2][1] = 2; dmem[2][2] = -3; dmem[2][3] = 4;
      do_job(0, 0, 65536, 0, 0, 0);
      do_job(2, 3, 2, 1, 0, 0);

      // Backpressure with a pending job, which is then taken on the first idle edge
      fill_random();
      do_job(3, 1, dot(3, 1), 3, 0, 1);
      do_job(3, 1, dot(3, 1), 0, 0, 0);

      // Randomized jobs
      for (int j = 0; j < 6; j++) begin
         fill_random();
         r = int'($urandom_range(ROWS - 1));
         c = int'($urandom_range(COLS - 1));
         do_job(r, c, dot(r, c), int'($urandom_range(2)), 0, 0);
      end

      // Job offer while busy is ignored
      do_job(1, 3, dot(1, 3), 0, 1, 0);
      @(negedge clk);
      check("ignore_busy", busy, 0);
      check("ignore_jobs_done", jobs_done, done_cnt);

      // Reset mid-FETCH
      bus.job_row   = ROW_W'(2);
      bus.job_col   = COL_W'(1);
      bus.job_valid = 1'b1;
      @(posedge clk);
      #1 bus.job_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("abort_rd_idx", bus.rd_idx, 2);
      #1 rst = 1'b1;
      #1;
      check("abort_rd_en", bus.rd_en, 0);
      check("abort_busy", busy, 0);
      check("abort_res_valid", bus.res_valid, 0);
      check("abort_jobs_done", jobs_done, 0);
      done_cnt = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      saw = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b0) saw = 1'b1;
      end
      check("abort_no_result", saw, 0);
      do_job(2, 1, dot(2, 1), 0, 0, 0);

      // Back-to-back after a fresh reset
      rst = 1'b1;
      #3 rst = 1'b0;
      done_cnt = 0;
      fill_random();
      bus.res_ready = 1'b1;
      bus.job_row   = ROW_W'(br[0]);
      bus.job_col   = COL_W'(bc[0]);
      bus.job_valid = 1'b1;
      for (int j = 0; j < 3; j++) begin
         n = 0;
         while (bus.job_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (n >= 50) check("b2b_accept_timeout", 0, 1);
         @(posedge clk);
         acc_cyc[j] = cyc;
         #1;
         if (j < 2) begin
            bus.job_row = ROW_W'(br[j + 1]);
            bus.job_col = COL_W'(bc[j + 1]);
         end else begin
            bus.job_valid = 1'b0;
         end
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (bus.res_valid !== 1'b1 && n < 20);
         check("b2b_res_valid", bus.res_valid, 1);
         check("b2b_res_data", bus.res_data, dot(br[j], bc[j]));
         check("b2b_res_row", bus.res_row, br[j]);
         check("b2b_res_col", bus.res_col, bc[j]);
      end
      @(posedge clk);
      #1 bus.res_ready = 1'b0;
      @(negedge clk);
      check("b2b_jobs_done", jobs_done, 3);
      check("b2b_spacing_1", acc_cyc[1] - acc_cyc[0], K + 3);
      check("b2b_spacing_2", acc_cyc[2] - acc_cyc[1], K + 3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/recompute_unit.md
RECOMPUTE_UNIT -- requirements
Module: recompute_unit

Interface
REQ-001 Parameter ROWS, default 4: systolic array rows; legal range is 2 or more.
REQ-002 Parameter COLS, default 4: systolic array columns; legal range is 2 or more.
REQ-003 Parameter K, default 4: dot-product length per recomputed PE output; legal range is 2 or more.
REQ-004 Parameter DATA_W, default 8: signed data and weight width.
REQ-005 Derived ACC_W = 2*DATA_W + clog2(K): signed accumulator and result width.
REQ-006 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-007 Port rst, input, 1 bit: reset; asynchronous, active-high.
REQ-008 Port job_valid, input, 1 bit: recompute job offered by the recompute controller.
REQ-009 Port job_ready, output, 1 bit: unit can accept a job.
REQ-010 Port job_row, input, clog2(ROWS) bits: faulty PE row.
REQ-011 Port job_col, input, clog2(COLS) bits: faulty PE column.
REQ-012 Port rd_en, output, 1 bit: operand read strobe.
REQ-013 Port rd_row, output, clog2(ROWS) bits: data-matrix row address (latched job_row).
REQ-014 Port rd_col, output, clog2(COLS) bits: weight-matrix column address (latched job_col).
REQ-015 Port rd_idx, output, clog2(K) bits: operand index k.
REQ-016 Port data_in, input, DATA_W bits signed: data[rd_row][k]; valid exactly one cycle after rd_en.
REQ-017 Port weight_in, input, DATA_W bits signed: weight[k][rd_col]; valid exactly one cycle after rd_en.
REQ-018 Port res_valid, output, 1 bit: corrected result available.
REQ-019 Port res_ready, input, 1 bit: downstream accepts the result.
REQ-020 Port res_row, output, clog2(ROWS) bits: row tag of the result.
REQ-021 Port res_col, output, clog2(COLS) bits: column tag of the result.
REQ-022 Port res_data, output, ACC_W bits signed: recomputed dot product.
REQ-023 Port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-024 Port jobs_done, output, 16 bits: count of completed result handshakes; saturates at 0xFFFF.

Function
REQ-025 The FSM SHALL have four states:
- IDLE: waiting for a job.
- FETCH: issuing operand reads.
- DRAIN: accumulating the last operand pair.
- DONE: holding the result until accepted.
REQ-026 job_ready SHALL equal (state==IDLE); a job is accepted on an edge where job_valid && job_ready.
REQ-027 On acceptance the unit SHALL:
- latch job_row and job_col;
- clear the accumulator;
- clear k to 0;
- move to FETCH.
REQ-028 In FETCH, rd_en SHALL be 1 and rd_idx SHALL equal k; k increments each edge.
REQ-029 The edge at which k==K-1 in FETCH SHALL move the FSM to DRAIN; rd_en SHALL be 0 in DRAIN, DONE and IDLE.
REQ-030 On every edge where rd_en was high in the previous cycle, acc SHALL become acc + data_in*weight_in, using a signed, full-precision product.
REQ-031 The DRAIN-exit edge SHALL add the final product and move to DONE.
REQ-032 res_valid SHALL be 1 only in DONE, i.e. K+1 edges after the acceptance edge.
REQ-033 While in DONE, res_data, res_row and res_col SHALL be stable until the res_valid && res_ready edge.
REQ-034 The result handshake edge SHALL:
- return the FSM to IDLE;
- increment jobs_done, unless it is already 0xFFFF.
REQ-035 res_ready held low SHALL stall indefinitely in DONE; no new job is accepted.
REQ-036 A job_valid asserted while busy SHALL be ignored; the upstream holds it until job_ready.
REQ-037 Back-to-back operation: the minimum job-to-job spacing SHALL be K+3 cycles (accept, K FETCH, DRAIN, DONE with res_ready=1, IDLE).
REQ-038 No overflow is possible: ACC_W holds K*(-2^(DATA_W-1))^2.

Reset
REQ-039 rst high SHALL immediately force the following, with no result emitted for an aborted job:
- state IDLE, acc 0, k 0;
- res_valid 0, rd_en 0, busy 0, jobs_done 0;
- res_data, res_row and res_col 0.
REQ-040 After rst deasserts, job_ready SHALL be 1 in the first cycle.

Verification
REQ-041 Basic job: job (row 1, col 2), data row [1,2,3,4], weight column [5,6,7,8] -> rd_idx 0..3 on 4 consecutive cycles; res_valid 5 edges after accept; res_data=70; res_row=1, res_col=2; jobs_done=1.
REQ-042 Signed extremes: all data -128, all weights -128, K=4 -> res_data=65536; mixed data [-1,2,-3,4] with weights [1,1,1,1] -> res_data=2.
REQ-043 Backpressure: res_ready low for 3 cycles after res_valid -> res_data stable, job_ready=0, and a pending job_valid is not accepted; release -> IDLE next edge.
REQ-044 Back-to-back: job_valid held high with res_ready=1 for 3 jobs -> acceptances exactly 7 cycles apart (K=4); correct tags per job; jobs_done=3.
REQ-045 Reset mid-FETCH: rst asserted at k=2 -> rd_en, busy and res_valid go to 0 asynchronously; no result; the next job recomputes correctly from acc=0.
REQ-046 Busy ignore: a job_valid pulse for one cycle during FETCH -> not accepted; jobs_done is unchanged by it.
